mem_dma: RTL and testbench

Memory-bus initiator that copies a block of 16-bit words from a source address to a destination address. Each word is one read transaction followed by one write transaction. It drives the same MEM_exec / MEM_ready / MEM_data_ready handshake the core uses, and attaches to the system memory responder in place of (or arbitrated with) the core. A control side starts a transfer, can abort it, and observes busy, done and a progress count.

---
 rtl/mem_dma_if.sv | 24 ++
 rtl/mem_dma.sv | 205 ++++++++++++++++++++
 tb/tb_mem_dma.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dma_if.sv
// Memory request/response bus shared by the core and the DMA initiator.
// master: drives MEM_exec/MEM_write/MEM_size/MEM_addr/MEM_data_out,
//         receives MEM_ready/MEM_data_in/MEM_data_ready.
// slave:  the memory responder side (directions reversed).
interface mem_dma_if;
  logic        MEM_ready;
  logic        MEM_exec;
  logic        MEM_write;
  logic [1:0]  MEM_size;
  logic [15:0] MEM_addr;
  logic [15:0] MEM_data_out;
  logic [15:0] MEM_data_in;
  logic        MEM_data_ready;

  modport master (
    output MEM_exec, MEM_write, MEM_size, MEM_addr, MEM_data_out,
    input  MEM_ready, MEM_data_in, MEM_data_ready
  );

  modport slave (
    input  MEM_exec, MEM_write, MEM_size, MEM_addr, MEM_data_out,
    output MEM_ready, MEM_data_in, MEM_data_ready
  );
endinterface

// File: rtl/mem_dma.sv
// mem_dma: block copy engine on the memory bus. Each word is one read
// followed by one write; abort is honoured only at a word boundary.
// Ports:
//   I_clk, I_reset (async, active low)
//   I_start/I_abort/I_src/I_dst/I_len/I_fill/I_fill_mode : control side
//   O_busy/O_done/O_aborted/O_count                       : status side
//   bus (mem_dma_if.master)                               : memory bus
// Optional feature: define MEM_DMA_FILL_EN to enable pattern fill
// (I_fill_mode = 1 at start writes I_fill to dst, no reads).
module mem_dma #(
  parameter int unsigned ADDR_STEP = 2
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_start,
  input  logic        I_abort,
  input  logic [15:0] I_src,
  input  logic [15:0] I_dst,
  input  logic [15:0] I_len,
  input  logic [15:0] I_fill,
  input  logic        I_fill_mode,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_aborted,
  output logic [15:0] O_count,
  mem_dma_if.master   bus
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [15:0]   rem_q, rem_d;
  logic [DW-1:0] buf_q, buf_d;
  logic [15:0]   count_q, count_d;
  logic          abort_q, abort_d;
  logic          aborted_q, aborted_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          exec_q, exec_d;
  logic          write_q, write_d;
  logic [1:0]    size_q, size_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
`ifdef MEM_DMA_FILL_EN
  logic          fill_q, fill_d;
`else
  logic          unused_fill;
  assign unused_fill = ^{I_fill, I_fill_mode};
`endif

  // Next-state, datapath and registered bus outputs
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    buf_d     = buf_q;
    count_d   = count_q;
    aborted_d = aborted_q;
    // abort is sticky once the engine leaves IDLE
    abort_d   = abort_q | (I_abort && (state_q != S_IDLE));
`ifdef MEM_DMA_FILL_EN
    fill_d    = fill_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (I_start) begin
          count_d   = '0;
          aborted_d = 1'b0;
          abort_d   = 1'b0;
          if (I_len != '0) begin
            src_d   = I_src;
            dst_d   = I_dst;
            rem_d   = I_len;
            state_d = S_RD_REQ;
`ifdef MEM_DMA_FILL_EN
            fill_d  = I_fill_mode;
            if (I_fill_mode) begin
              buf_d   = I_fill;
              state_d = S_WR_REQ;
            end
`endif
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RD_REQ:  if (bus.MEM_ready) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (bus.MEM_data_ready) begin
          buf_d   = bus.MEM_data_in;
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ:  if (bus.MEM_ready) state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (bus.MEM_data_ready) begin
          count_d = count_q + 16'd1;
          dst_d   = dst_q + AW'(ADDR_STEP);
          src_d   = src_q + AW'(ADDR_STEP);
          rem_d   = rem_q - 16'd1;
          state_d = S_RD_REQ;
`ifdef MEM_DMA_FILL_EN
          if (fill_q) begin
            src_d   = src_q;
            state_d = S_WR_REQ;
          end
`endif
          if ((rem_q == 16'd1) || abort_q || I_abort) begin
            aborted_d = abort_q | I_abort;
            state_d   = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Bus request fields are loaded on entry to a request state and then held
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    exec_d  = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_d == S_RD_REQ) begin
      write_d = 1'b0;
      size_d  = SIZE_WORD;
      addr_d  = src_d;
    end else if (state_d == S_WR_REQ) begin
      write_d = 1'b1;
      size_d  = SIZE_WORD;
      addr_d  = dst_d;
      wdata_d = buf_d;
    end
  end

  // State and output registers
  always_ff @(posedge I_clk or negedge I_reset) begin
    if (!I_reset) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      buf_q     <= '0;
      count_q   <= '0;
      abort_q   <= 1'b0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      exec_q    <= 1'b0;
      write_q   <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
`ifdef MEM_DMA_FILL_EN
      fill_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      buf_q     <= buf_d;
      count_q   <= count_d;
      abort_q   <= abort_d;
      aborted_q <= aborted_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      exec_q    <= exec_d;
      write_q   <= write_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
`ifdef MEM_DMA_FILL_EN
      fill_q    <= fill_d;
`endif
    end
  end

  assign O_busy           = busy_q;
  assign O_done           = done_q;
  assign O_aborted        = aborted_q;
  assign O_count          = count_q;
  assign bus.MEM_exec     = exec_q;
  assign bus.MEM_write    = write_q;
  assign bus.MEM_size     = size_q;
  assign bus.MEM_addr     = addr_q;
  assign bus.MEM_data_out = wdata_q;

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: a 3-cycle memory responder model with a transaction
// scoreboard (expected bus transactions queued by each test, popped and
// compared as the responder accepts requests).
module tb_mem_dma;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] src, dst, len, fill;
  logic        fill_mode;
  logic        busy, done, aborted;
  logic [15:0] count;

  mem_dma_if mem ();

  mem_dma #(.ADDR_STEP(2)) dut (
    .I_clk(clk), .I_reset(rst_n), .I_start(start), .I_abort(abort),
    .I_src(src), .I_dst(dst), .I_len(len), .I_fill(fill),
    .I_fill_mode(fill_mode), .O_busy(busy), .O_done(done),
    .O_aborted(aborted), .O_count(count), .bus(mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [15:0] mem_arr[logic [15:0]];
  int          checks = 0;
  int          errors = 0;
  int          rd_acc = 0;
  int          wr_acc = 0;
  int          done_cnt = 0;
  int          exec_cyc = 0;

  bit          r_busy = 0;
  int          r_lat  = 0;
  logic [15:0] r_rdata;

  // Memory responder: accept on exec&ready, data_ready 3 cycles after exec
  always @(posedge clk) begin
    if (!rst_n) begin
      #1;
      r_busy = 0;
      mem.MEM_data_ready = 1'b0;
      mem.MEM_ready = 1'b1;
    end else if (r_busy) begin
      if (mem.MEM_data_ready) begin
        #1;
        mem.MEM_data_ready = 1'b0;
        mem.MEM_ready = 1'b1;
        r_busy = 0;
      end else if (r_lat == 0) begin
        #1;
        mem.MEM_data_in = r_rdata;
        mem.MEM_data_ready = 1'b1;
      end else begin
        r_lat--;
      end
    end else if (mem.MEM_exec && mem.MEM_ready) begin
      txn_t got;
      got.wr = mem.MEM_write;
      got.addr = mem.MEM_addr;
      got.data = mem.MEM_write ? mem.MEM_data_out : 16'h0000;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_txn: got wr=%0b addr=%h data=%h, required none", got.wr, got.addr, got.data);
      end else begin
        txn_t e;
        e = exp_q.pop_front();
        if (got.wr !== e.wr || got.addr !== e.addr || got.data !== e.data || mem.MEM_size !== 2'b10) begin
          errors++;
          $display("FAIL txn: got wr=%0b addr=%h data=%h size=%b, required wr=%0b addr=%h data=%h size=10",
                   got.wr, got.addr, got.data, mem.MEM_size, e.wr, e.addr, e.data);
        end
      end
      if (got.wr) begin
        mem_arr[got.addr] = got.data;
        wr_acc++;
        r_rdata = 16'h0000;
      end else begin
        rd_acc++;
        r_rdata = mem_arr.exists(got.addr) ? mem_arr[got.addr] : (got.addr ^ 16'h5A5A);
      end
      r_busy = 1;
      r_lat = 1;
      #1;
      mem.MEM_ready = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (mem.MEM_exec === 1'b1) exec_cyc++;
  end

  task automatic push_txn(input logic w, input logic [15:0] a, input logic [15:0] d);
    txn_t t;
    t.wr = w; t.addr = a; t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic start_xfer(input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] l, input logic fm);
    @(negedge clk);
    src = s; dst = d; len = l; fill_mode = fm; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for O_done at negedges; returns cycles waited or -1 on timeout
  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        at = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, aborted} !== 3'b000 || count !== 16'h0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b done=%b aborted=%b count=%h, required 0", busy, done, aborted, count);
    end
    checks++;
    if ({mem.MEM_exec, mem.MEM_write, mem.MEM_size} !== 4'b0 || mem.MEM_addr !== 16'h0 || mem.MEM_data_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_bus: got exec=%b write=%b size=%b addr=%h data=%h, required 0",
               mem.MEM_exec, mem.MEM_write, mem.MEM_size, mem.MEM_addr, mem.MEM_data_out);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_copy();
    int at;
    int d0;
    mem_arr[16'h0100] = 16'h1111;
    mem_arr[16'h0102] = 16'h2222;
    mem_arr[16'h0104] = 16'h3333;
    push_txn(0, 16'h0100, 16'h0); push_txn(1, 16'h0200, 16'h1111);
    push_txn(0, 16'h0102, 16'h0); push_txn(1, 16'h0202, 16'h2222);
    push_txn(0, 16'h0104, 16'h0); push_txn(1, 16'h0204, 16'h3333);
    d0 = done_cnt;
    start_xfer(16'h0100, 16'h0200, 16'd3, 1'b0);
    checks++;
    if (mem.MEM_exec !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL copy_first_exec: got exec=%b busy=%b, required 1 1", mem.MEM_exec, busy);
    end
    wait_done(100, at);
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL copy_timeout: got no done, required done within 100 cycles");
    end
    checks++;
    if (count !== 16'd3 || aborted !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL copy_status: got count=%0d aborted=%b busy=%b, required 3 0 1", count, aborted, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || done_cnt - d0 !== 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL copy_end: got busy=%b done=%b pulses=%0d pending=%0d, required 0 0 1 0",
               busy, done, done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_len_zero();
    int at;
    int e0, d0;
    e0 = exec_cyc;
    d0 = done_cnt;
    start_xfer(16'h1000, 16'h2000, 16'd0, 1'b0);
    wait_done(10, at);
    checks++;
    if (at < 0 || at > 1) begin
      errors++;
      $display("FAIL len0_done_time: got %0d, required done within 2 cycles of start", at);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (exec_cyc != e0 || count !== 16'd0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL len0_quiet: got exec_cycles=%0d count=%0d pulses=%0d, required 0 0 1",
               exec_cyc - e0, count, done_cnt - d0);
    end
  endtask

  task automatic test_stall();
    int at;
    int r0;
    r0 = rd_acc;
    mem_arr[16'h0400] = 16'h4444;
    push_txn(0, 16'h0400, 16'h0); push_txn(1, 16'h0500, 16'h4444);
    @(negedge clk);
    mem.MEM_ready = 1'b0;
    start_xfer(16'h0400, 16'h0500, 16'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (mem.MEM_exec !== 1'b1 || mem.MEM_addr !== 16'h0400 || mem.MEM_write !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got exec=%b addr=%h write=%b, required 1 0400 0",
                 i, mem.MEM_exec, mem.MEM_addr, mem.MEM_write);
      end
    end
    mem.MEM_ready = 1'b1;
    wait_done(100, at);
    checks++;
    if (at < 0 || rd_acc - r0 != 1 || count !== 16'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_end: got at=%0d reads=%0d count=%0d pending=%0d, required reads=1 count=1 pending=0",
               at, rd_acc - r0, count, exp_q.size());
    end
  endtask

  task automatic test_abort();
    int at;
    int r0, w0;
    bit seen;
    r0 = rd_acc;
    w0 = wr_acc;
    mem_arr[16'h0600] = 16'h6000;
    mem_arr[16'h0602] = 16'h6002;
    push_txn(0, 16'h0600, 16'h0); push_txn(1, 16'h0700, 16'h6000);
    push_txn(0, 16'h0602, 16'h0); push_txn(1, 16'h0702, 16'h6002);
    start_xfer(16'h0600, 16'h0700, 16'd4, 1'b0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_acc - r0 == 2) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL abort_reach_word1: got reads=%0d, required 2", rd_acc - r0);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(100, at);
    checks++;
    if (at < 0 || aborted !== 1'b1 || count !== 16'd2) begin
      errors++;
      $display("FAIL abort_status: got at=%0d aborted=%b count=%0d, required aborted=1 count=2", at, aborted, count);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (rd_acc - r0 != 2 || wr_acc - w0 != 2 || aborted !== 1'b1) begin
      errors++;
      $display("FAIL abort_after: got reads=%0d writes=%0d aborted=%b, required 2 2 1", rd_acc - r0, wr_acc - w0, aborted);
    end
  endtask

  task automatic test_wrap();
    int at;
    mem_arr[16'hFFFE] = 16'hBEEF;
    mem_arr[16'h0000] = 16'hCAFE;
    push_txn(0, 16'hFFFE, 16'h0); push_txn(1, 16'h0800, 16'hBEEF);
    push_txn(0, 16'h0000, 16'h0); push_txn(1, 16'h0802, 16'hCAFE);
    start_xfer(16'hFFFE, 16'h0800, 16'd2, 1'b0);
    // a second start while busy must be ignored
    repeat (3) @(negedge clk);
    src = 16'h3000; dst = 16'h3100; len = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100, at);
    checks++;
    if (at < 0 || count !== 16'd2 || aborted !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap: got at=%0d count=%0d aborted=%b pending=%0d, required count=2 aborted=0 pending=0",
               at, count, aborted, exp_q.size());
    end
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_while_busy: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_async_reset();
    int at;
    int w0;
    bit seen;
    w0 = wr_acc;
    mem_arr[16'h0900] = 16'h1234;
    push_txn(0, 16'h0900, 16'h0); push_txn(1, 16'h0A00, 16'h1234);
    start_xfer(16'h0900, 16'h0A00, 16'd2, 1'b0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_acc - w0 == 1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL areset_reach_wr_wait: got writes=%0d, required 1", wr_acc - w0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, aborted} !== 3'b000 || count !== 16'h0 ||
        {mem.MEM_exec, mem.MEM_write, mem.MEM_size} !== 4'b0 ||
        mem.MEM_addr !== 16'h0 || mem.MEM_data_out !== 16'h0) begin
      errors++;
      $display("FAIL areset_outputs: got busy=%b done=%b ab=%b cnt=%h exec=%b wr=%b size=%b addr=%h data=%h, required all 0",
               busy, done, aborted, count, mem.MEM_exec, mem.MEM_write, mem.MEM_size, mem.MEM_addr, mem.MEM_data_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mem_arr[16'h0B00] = 16'h5678;
    push_txn(0, 16'h0B00, 16'h0); push_txn(1, 16'h0C00, 16'h5678);
    start_xfer(16'h0B00, 16'h0C00, 16'd1, 1'b0);
    wait_done(100, at);
    checks++;
    if (at < 0 || count !== 16'd1 || aborted !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL areset_restart: got at=%0d count=%0d aborted=%b pending=%0d, required count=1 aborted=0 pending=0",
               at, count, aborted, exp_q.size());
    end
  endtask

`ifdef MEM_DMA_FILL_EN
  task automatic test_fill();
    int at;
    int r0;
    r0 = rd_acc;
    fill = 16'hA5A5;
    push_txn(1, 16'h0300, 16'hA5A5); push_txn(1, 16'h0302, 16'hA5A5);
    start_xfer(16'h0000, 16'h0300, 16'd2, 1'b1);
    wait_done(100, at);
    fill_mode = 1'b0;
    checks++;
    if (at < 0 || count !== 16'd2 || rd_acc != r0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL fill: got at=%0d count=%0d reads=%0d pending=%0d, required count=2 reads=0 pending=0",
               at, count, rd_acc - r0, exp_q.size());
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    src = '0; dst = '0; len = '0; fill = '0; fill_mode = 1'b0;
    mem.MEM_ready = 1'b1;
    mem.MEM_data_ready = 1'b0;
    mem.MEM_data_in = '0;
    test_reset();
    test_copy();
    test_len_zero();
    test_stall();
    test_abort();
    test_wrap();
    test_async_reset();
`ifdef MEM_DMA_FILL_EN
    test_fill();
`endif
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
